// File: rtl/ps2_frame_receiver_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_frame_receiver_if
//  Description : Bundle of the PS/2 receive pins and the validated scan-code
//                output of ps2_frame_receiver.
//                master : the receiver (samples the pins, drives the byte
//                         and strobes)
//                slave  : the consumer / pin source (drives the pins,
//                         observes the byte and strobes)
//  Ports       : ps2_clk, ps2_data        raw asynchronous PS/2 pins
//                received_data[7:0]       last valid scan-code byte
//                received_data_en         one-cycle valid strobe
//                parity_error             one-cycle bad-parity strobe
//                frame_error              one-cycle bad-stop/timeout strobe
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_frame_receiver_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       parity_error;
    logic       frame_error;

    modport master (
        input  ps2_clk,
        input  ps2_data,
        output received_data,
        output received_data_en,
        output parity_error,
        output frame_error
    );

    modport slave (
        output ps2_clk,
        output ps2_data,
        input  received_data,
        input  received_data_en,
        input  parity_error,
        input  frame_error
    );
endinterface
`default_nettype wire

// File: rtl/ps2_frame_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_frame_receiver
//  Description : Receive-only PS/2 frame receiver. Synchronises the raw pins,
//                glitch-filters the PS/2 clock, samples 11-bit frames on the
//                filtered falling edge, checks start/odd-parity/stop and
//                recovers from stalled frames with an inter-bit timeout.
//  Ports       : clk    system clock (rising edge)
//                reset  synchronous active-high reset
//                bus    ps2_frame_receiver_if.master (pins in, byte and
//                       strobes out)
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_frame_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic                 clk,
    input  logic                 reset,
    ps2_frame_receiver_if.master bus
);
    localparam int c_FILT_W = $clog2(FILTER_LEN + 1);
    localparam int c_TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_FILT_W-1:0] c_FILT_MAX = c_FILT_W'(FILTER_LEN);
    localparam logic [c_FILT_W-1:0] c_FILT_ONE = c_FILT_W'(1);
    localparam logic [c_TO_W-1:0]   c_TO_LAST  = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TO_W-1:0]   c_TO_ONE   = c_TO_W'(1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_DATA   = 2'd1;
    localparam logic [1:0] c_PARITY = 2'd2;
    localparam logic [1:0] c_STOP   = 2'd3;

    logic [1:0]          r_clk_sync;
    logic [1:0]          r_data_sync;
    logic [c_FILT_W-1:0] r_filt_cnt;
    logic                r_filt_clk;
    logic                r_filt_clk_d;
    logic                r_fall;
    logic [1:0]          r_state;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic                r_parity;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic [7:0]          r_rx_data;
    logic                r_rx_en;
    logic                r_par_err;
    logic                r_frm_err;

    logic                w_bit;
    logic                w_timeout;

    assign w_bit     = r_data_sync[1];
    // Only an in-progress frame can time out; IDLE holds the counter at zero.
    assign w_timeout = (r_state != c_IDLE) && (r_to_cnt == c_TO_LAST);

    // Two-flop synchronisers; idle-high so reset looks like a released bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], bus.ps2_clk};
            r_data_sync <= {r_data_sync[0], bus.ps2_data};
        end
    end

    // Glitch filter: the filtered clock follows the synchronised clock only
    // after FILTER_LEN consecutive cycles of disagreement. The counter
    // reaches FILTER_LEN on the same edge the level flips, then clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_filt_cnt   <= '0;
            r_filt_clk   <= 1'b1;
            r_filt_clk_d <= 1'b1;
            r_fall       <= 1'b0;
        end else begin
            r_filt_clk_d <= r_filt_clk;
            r_fall       <= r_filt_clk_d & ~r_filt_clk;
            if (r_clk_sync[1] == r_filt_clk) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt != c_FILT_MAX) begin
                r_filt_cnt <= r_filt_cnt + c_FILT_ONE;
                if (r_filt_cnt == c_FILT_MAX - c_FILT_ONE) begin
                    r_filt_clk <= r_clk_sync[1];
                end
            end
        end
    end

    // Frame FSM, timeout and registered result strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_to_cnt  <= '0;
            r_rx_data <= 8'h00;
            r_rx_en   <= 1'b0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
        end else begin
            r_rx_en   <= 1'b0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;

            if ((r_state == c_IDLE) || r_fall) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + c_TO_ONE;
            end

            // A timeout wins over a coincident fall; that bit is dropped.
            if (w_timeout) begin
                r_state   <= c_IDLE;
                r_frm_err <= 1'b1;
            end else if (r_fall) begin
                case (r_state)
                    c_IDLE: begin
                        // A high "start" bit is a false start: stay idle.
                        if (!w_bit) begin
                            r_state   <= c_DATA;
                            r_bit_cnt <= '0;
                            r_shift   <= '0;
                        end
                    end
                    c_DATA: begin
                        // LSB arrives first, so shift right from bit 7.
                        r_shift   <= {w_bit, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= c_PARITY;
                        end
                    end
                    c_PARITY: begin
                        r_parity <= w_bit;
                        r_state  <= c_STOP;
                    end
                    c_STOP: begin
                        r_state <= c_IDLE;
                        // Bad stop bit masks any parity result.
                        if (!w_bit) begin
                            r_frm_err <= 1'b1;
                        end else if (^{r_shift, r_parity}) begin
                            r_rx_data <= r_shift;
                            r_rx_en   <= 1'b1;
                        end else begin
                            r_par_err <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= c_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.received_data    = r_rx_data;
    assign bus.received_data_en = r_rx_en;
    assign bus.parity_error     = r_par_err;
    assign bus.frame_error      = r_frm_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_frame_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_frame_receiver
//  Description : Self-checking bench for ps2_frame_receiver: table of
//                directed frames, multi-cycle corner sequences (glitch,
//                timeout, mid-frame reset) and random frames checked
//                against a rule-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_frame_receiver;
    localparam int c_FL = 8;
    localparam int c_TO = 200;

    localparam int K_DATA = 1;
    localparam int K_PAR  = 2;
    localparam int K_FRM  = 3;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         kind;
        logic [7:0] rx;
    } vec_t;

    typedef struct {
        int         kind;
        logic [7:0] data;
        longint     cyc;
    } ev_t;

    logic   clk;
    logic   reset;
    longint cyc = 0;
    logic   rst_q = 1'b1;
    longint last_fall_cyc = 0;
    int     checks = 0;
    int     errors = 0;
    logic   mon_en = 1'b0;
    logic [7:0] prev_rx = 8'h00;
    logic   prev_strobe = 1'b0;
    ev_t    evq[$];

    ps2_frame_receiver_if bus_if ();

    ps2_frame_receiver #(
        .FILTER_LEN     (c_FL),
        .TIMEOUT_CYCLES (c_TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    // Strobe monitor: exclusivity, single-cycle width, data hold.
    always @(negedge clk) begin
        logic [2:0] s;
        ev_t        e;
        s = {bus_if.received_data_en, bus_if.parity_error, bus_if.frame_error};
        if (mon_en && !rst_q) begin
            if (s != 3'b000) begin
                checks++;
                if ($countones(s) != 1 || prev_strobe) begin
                    errors++;
                    $display("FAIL strobe_shape: en/pe/fe=%b prev_strobe=%b, required exactly one single-cycle strobe",
                             s, prev_strobe);
                end
                e.kind = bus_if.received_data_en ? K_DATA : (bus_if.parity_error ? K_PAR : K_FRM);
                e.data = bus_if.received_data;
                e.cyc  = cyc;
                evq.push_back(e);
            end
            if (bus_if.received_data !== prev_rx && !bus_if.received_data_en) begin
                checks++;
                errors++;
                $display("FAIL data_hold: received_data changed %h -> %h without received_data_en",
                         prev_rx, bus_if.received_data);
            end
        end
        prev_rx     = bus_if.received_data;
        prev_strobe = (s != 3'b000);
    end

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic p, input logic st);
        return {st, p, d, 1'b0};
    endfunction

    // Reference model: outcome of a complete frame from its bit values alone.
    function automatic int ref_outcome(input logic [7:0] d, input logic p, input logic st);
        if (!st) return K_FRM;
        if (($countones({d, p}) % 2) == 1) return K_DATA;
        return K_PAR;
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n, input int half);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus_if.ps2_data = bits[i];
            repeat (half) @(negedge clk);
            bus_if.ps2_clk = 1'b0;
            last_fall_cyc  = cyc;
            repeat (half) @(negedge clk);
            bus_if.ps2_clk = 1'b1;
        end
    endtask

    task automatic expect_one(input string name, input int kind, input logic [7:0] exp_rx);
        ev_t e;
        repeat (c_FL + 10) @(negedge clk);
        checks++;
        if (evq.size() == 0) begin
            errors++;
            $display("FAIL %s_strobe: no strobe seen, required kind %0d data %h", name, kind, exp_rx);
        end else begin
            e = evq.pop_front();
            if (e.kind != kind || (kind == K_DATA && e.data !== exp_rx)) begin
                errors++;
                $display("FAIL %s_strobe: got kind %0d data %h, required kind %0d data %h",
                         name, e.kind, e.data, kind, exp_rx);
            end
            checks++;
            if (e.cyc - last_fall_cyc != longint'(c_FL + 4)) begin
                errors++;
                $display("FAIL %s_latency: strobe %0d cycles after stop fall, required %0d",
                         name, e.cyc - last_fall_cyc, c_FL + 4);
            end
        end
        checks++;
        if (bus_if.received_data !== exp_rx || evq.size() != 0) begin
            errors++;
            $display("FAIL %s_data: received_data %h extra_strobes %0d, required %h and 0",
                     name, bus_if.received_data, evq.size(), exp_rx);
        end
        evq.delete();
    endtask

    task automatic expect_none(input string name, input logic [7:0] exp_rx);
        checks++;
        if (evq.size() != 0 || bus_if.received_data !== exp_rx) begin
            errors++;
            $display("FAIL %s: strobes %0d received_data %h, required 0 strobes and %h",
                     name, evq.size(), bus_if.received_data, exp_rx);
        end
        evq.delete();
    endtask

    vec_t tbl[10];

    initial begin
        logic [7:0] model_rx;
        logic [7:0] d;
        logic       p;
        logic       st;
        int         half;
        int         k;
        longint     fall6;
        ev_t        e;
        logic [10:0] fr;

        tbl[0] = '{8'h1C, 1'b0, 1'b1, K_DATA, 8'h1C};
        tbl[1] = '{8'h1C, 1'b1, 1'b1, K_PAR,  8'h1C};
        tbl[2] = '{8'h75, 1'b0, 1'b0, K_FRM,  8'h1C};
        tbl[3] = '{8'h75, 1'b1, 1'b0, K_FRM,  8'h1C};
        tbl[4] = '{8'h74, 1'b1, 1'b1, K_DATA, 8'h74};
        tbl[5] = '{8'h00, 1'b1, 1'b1, K_DATA, 8'h00};
        tbl[6] = '{8'hFF, 1'b1, 1'b1, K_DATA, 8'hFF};
        tbl[7] = '{8'hFF, 1'b0, 1'b1, K_PAR,  8'hFF};
        tbl[8] = '{8'h29, 1'b1, 1'b1, K_PAR,  8'hFF};
        tbl[9] = '{8'h5A, 1'b1, 1'b1, K_DATA, 8'h5A};

        bus_if.ps2_clk  = 1'b1;
        bus_if.ps2_data = 1'b1;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_if.received_data !== 8'h00 || bus_if.received_data_en !== 1'b0 ||
            bus_if.parity_error !== 1'b0 || bus_if.frame_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: data=%h en=%b pe=%b fe=%b, required 00 0 0 0",
                     bus_if.received_data, bus_if.received_data_en,
                     bus_if.parity_error, bus_if.frame_error);
        end
        mon_en = 1'b1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            send_bits(mk_frame(tbl[i].data, tbl[i].par, tbl[i].stop), 11, 40);
            expect_one($sformatf("tbl%0d", i), tbl[i].kind, tbl[i].rx);
        end

        // E0, F0, 75 with a short clock glitch between the first two frames
        send_bits(mk_frame(8'hE0, 1'b0, 1'b1), 11, 40);
        repeat (10) @(negedge clk);
        bus_if.ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        bus_if.ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
        send_bits(mk_frame(8'hF0, 1'b1, 1'b1), 11, 40);
        send_bits(mk_frame(8'h75, 1'b0, 1'b1), 11, 40);
        repeat (c_FL + 10) @(negedge clk);
        checks++;
        if (evq.size() != 3 ||
            evq[0].kind != K_DATA || evq[0].data !== 8'hE0 ||
            evq[1].kind != K_DATA || evq[1].data !== 8'hF0 ||
            evq[2].kind != K_DATA || evq[2].data !== 8'h75) begin
            errors++;
            $display("FAIL seq_e0f075: %0d strobes, required three data strobes E0 F0 75", evq.size());
        end
        evq.delete();

        // Stalled frame: start + 5 data bits, then idle
        send_bits(mk_frame(8'h15, 1'b0, 1'b1), 6, 40);
        fall6 = last_fall_cyc;
        bus_if.ps2_data = 1'b1;
        repeat (c_TO + 60) @(negedge clk);
        checks++;
        if (evq.size() != 1) begin
            errors++;
            $display("FAIL timeout_strobe: %0d strobes, required exactly one frame_error", evq.size());
        end else begin
            e = evq.pop_front();
            // fall pulse is seen FILTER_LEN+3 cycles after the raw fall
            if (e.kind != K_FRM || e.cyc - (fall6 + c_FL + 3) < c_TO ||
                e.cyc - (fall6 + c_FL + 3) > c_TO + 2) begin
                errors++;
                $display("FAIL timeout_strobe: kind %0d after %0d cycles, required kind %0d after %0d..%0d",
                         e.kind, e.cyc - (fall6 + c_FL + 3), K_FRM, c_TO, c_TO + 2);
            end
        end
        evq.delete();
        send_bits(mk_frame(8'hF0, 1'b1, 1'b1), 11, 40);
        expect_one("after_timeout", K_DATA, 8'hF0);

        // Mid-frame reset after the 4th data bit; remainder is all ones
        fr = mk_frame(8'hF3, 1'b1, 1'b1);
        send_bits(fr, 5, 40);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_if.received_data !== 8'h00 || bus_if.received_data_en !== 1'b0 ||
            bus_if.parity_error !== 1'b0 || bus_if.frame_error !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: data=%h en=%b pe=%b fe=%b, required 00 0 0 0",
                     bus_if.received_data, bus_if.received_data_en,
                     bus_if.parity_error, bus_if.frame_error);
        end
        send_bits(fr >> 5, 6, 40);
        repeat (c_TO + 40) @(negedge clk);
        expect_none("midreset_remainder", 8'h00);
        send_bits(mk_frame(8'h29, 1'b0, 1'b1), 11, 40);
        expect_one("after_reset", K_DATA, 8'h29);

        // Random frames against the reference model
        model_rx = 8'h29;
        for (int i = 0; i < 24; i++) begin
            half = $urandom_range(20, 60);
            d    = 8'($urandom);
            p    = ($urandom_range(0, 3) != 0) ? ~^d : ^d;
            st   = ($urandom_range(0, 7) != 0);
            k    = ref_outcome(d, p, st);
            if (k == K_DATA) model_rx = d;
            send_bits(mk_frame(d, p, st), 11, half);
            expect_one($sformatf("rnd%0d", i), k, model_rx);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
